vt100_response_tx: RTL

- Generates the terminal-to-host reply byte stream for VT100 queries. This is the transmit-direction counterpart of the command parser.
- Takes one-cycle query requests from the command dispatch logic and serialises the matching escape-sequence reply onto a byte valid/ready interface that feeds the UART transmitter.
- Supported replies: Device Status Report, Cursor Position Report and Device Attributes.

---
 rtl/vt100_response_tx_if.sv | 33 +++
 rtl/vt100_response_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vt100_response_tx_if.sv
// vt100_response_tx_if: request and reply-byte handshake bundle for vt100_response_tx.
// Latency: none, wires only.
// Backpressure: reqReady throttles query requests; txReady stalls reply bytes.
//
// Signals:
//   reqValid/reqType/reqReady  query request handshake (type 0=DSR 1=CPR 2=DA 3=reserved)
//   cursorX/cursorY            0-based cursor column/row, sampled on request acceptance
//   txData/txValid/txReady     reply byte stream towards the UART transmitter
//   busy                       a reply is in progress (or queued)
// Modports: master = request source / byte sink, slave = reply generator.
interface vt100_response_tx_if #(
  parameter int COORD_W = 8
);
  logic               reqValid;
  logic [1:0]         reqType;
  logic               reqReady;
  logic [COORD_W-1:0] cursorX;
  logic [COORD_W-1:0] cursorY;
  logic [7:0]         txData;
  logic               txValid;
  logic               txReady;
  logic               busy;

  modport master (
    output reqValid, reqType, cursorX, cursorY, txReady,
    input  reqReady, txData, txValid, busy
  );

  modport slave (
    input  reqValid, reqType, cursorX, cursorY, txReady,
    output reqReady, txData, txValid, busy
  );
endinterface

// File: rtl/vt100_response_tx.sv
// vt100_response_tx: serialises VT100 query replies (DSR, CPR, DA) onto a byte stream.
// Latency: first reply byte valid the cycle after acceptance; no bubbles inside a reply.
// Backpressure: txReady low holds txData/txValid; reqReady low while a reply is active (or queue full).
//
// Ports:
//   i_clk   system clock
//   i_rst   synchronous reset, active-low
//   io_bus  vt100_response_tx_if.slave (request in, reply bytes out, busy)
// Optional build macro: VT100_RESP_QUEUE_EN adds a 4-entry request queue so
// replies stream back-to-back; without it only one request is held at a time.
module vt100_response_tx #(
  parameter int COORD_W = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  vt100_response_tx_if.slave   io_bus
);

  localparam int CW1 = COORD_W + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched reply context.
  logic [1:0]  r_type;
  logic [11:0] r_row_bcd;
  logic [1:0]  r_row_nd;
  logic [11:0] r_col_bcd;
  logic [1:0]  r_col_nd;
  logic [3:0]  r_last_idx;
  logic [3:0]  r_idx;

  // Request presented to the reply engine this cycle.
  logic               w_ld_vld;
  logic [1:0]         w_ld_type;
  logic [COORD_W-1:0] w_ld_x;
  logic [COORD_W-1:0] w_ld_y;

  logic       w_xfer;
  logic       w_last;
  logic       w_tx_vld;
  logic [7:0] w_tx_dat;

  // Shift-add-3 binary to BCD, 9-bit input (max 256) into 3 digits.
  function automatic logic [11:0] f_bin2bcd(input logic [8:0] bin);
    logic [20:0] sr;
    sr = {12'd0, bin};
    for (int i = 0; i < 9; i++) begin
      if (sr[12:9]  >= 4'd5) sr[12:9]  = sr[12:9]  + 4'd3;
      if (sr[16:13] >= 4'd5) sr[16:13] = sr[16:13] + 4'd3;
      if (sr[20:17] >= 4'd5) sr[20:17] = sr[20:17] + 4'd3;
      sr = sr << 1;
    end
    return sr[20:9];
  endfunction

  function automatic logic [1:0] f_ndig(input logic [8:0] v);
    if (v >= 9'd100)     return 2'd3;
    else if (v >= 9'd10) return 2'd2;
    else                 return 2'd1;
  endfunction

  // ASCII for the k-th digit (0 = most significant) of an nd-digit number.
  function automatic logic [7:0] f_digit(input logic [11:0] bcd, input logic [1:0] nd,
                                         input logic [1:0] k);
    logic [1:0] p;
    logic [3:0] nib;
    p = nd - k - 2'd1;
    case (p)
      2'd0:    nib = bcd[3:0];
      2'd1:    nib = bcd[7:4];
      default: nib = bcd[11:8];
    endcase
    return {4'h3, nib};
  endfunction

  assign w_xfer = (r_state == S_EMIT) && io_bus.txReady;
  assign w_last = (r_idx == r_last_idx);

`ifdef VT100_RESP_QUEUE_EN
  localparam int QW = 2 + 2 * COORD_W;

  logic [QW-1:0]      r_q_mem [4];
  logic [1:0]         r_q_wp;
  logic [1:0]         r_q_rp;
  logic [2:0]         r_q_cnt;
  logic               w_q_full;
  logic               w_q_empty;
  logic               w_q_push;
  logic               w_q_pop;
  logic               w_acc;
  logic               w_slot;
  logic               w_byp;
  logic [1:0]         w_h_type;
  logic [COORD_W-1:0] w_h_x;
  logic [COORD_W-1:0] w_h_y;

  assign w_q_full        = (r_q_cnt == 3'd4);
  assign w_q_empty       = (r_q_cnt == 3'd0);
  assign io_bus.reqReady = !w_q_full;
  // Reserved type is dropped at the queue input.
  assign w_acc  = io_bus.reqValid && io_bus.reqReady && (io_bus.reqType != 2'd3);
  // Engine can take a new request now: idle, or the last byte leaves this edge.
  assign w_slot = (r_state == S_IDLE) || (w_xfer && w_last);
  // Empty queue with a free engine: route the request straight in, so the
  // first byte still comes one cycle after acceptance.
  assign w_byp    = w_slot && w_q_empty && w_acc;
  assign w_q_pop  = w_slot && !w_q_empty;
  assign w_q_push = w_acc && !w_byp;

  assign {w_h_type, w_h_x, w_h_y} = r_q_mem[r_q_rp];
  assign w_ld_vld  = w_q_pop || w_byp;
  assign w_ld_type = w_q_empty ? io_bus.reqType : w_h_type;
  assign w_ld_x    = w_q_empty ? io_bus.cursorX : w_h_x;
  assign w_ld_y    = w_q_empty ? io_bus.cursorY : w_h_y;

  assign io_bus.busy = (r_state != S_IDLE) || !w_q_empty;

  always_ff @(posedge i_clk) begin
    if (w_q_push) r_q_mem[r_q_wp] <= {io_bus.reqType, io_bus.cursorX, io_bus.cursorY};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_q_wp  <= 2'd0;
      r_q_rp  <= 2'd0;
      r_q_cnt <= 3'd0;
    end else begin
      if (w_q_push) r_q_wp <= r_q_wp + 2'd1;
      if (w_q_pop)  r_q_rp <= r_q_rp + 2'd1;
      case ({w_q_push, w_q_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 3'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 3'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end
`else
  assign io_bus.reqReady = (r_state == S_IDLE) && i_rst;
  assign w_ld_vld  = io_bus.reqValid && io_bus.reqReady && (io_bus.reqType != 2'd3);
  assign w_ld_type = io_bus.reqType;
  assign w_ld_x    = io_bus.cursorX;
  assign w_ld_y    = io_bus.cursorY;
  assign io_bus.busy = (r_state != S_IDLE);
`endif

  // 1-based coordinates at COORD_W+1 bits so 255 becomes 256, not 0.
  logic [CW1-1:0] w_row;
  logic [CW1-1:0] w_col;
  logic [8:0]     w_row9;
  logic [8:0]     w_col9;
  logic [1:0]     w_row_nd;
  logic [1:0]     w_col_nd;
  logic [3:0]     w_ld_last;

  assign w_row    = {1'b0, w_ld_y} + CW1'(1);
  assign w_col    = {1'b0, w_ld_x} + CW1'(1);
  assign w_row9   = 9'(w_row);
  assign w_col9   = 9'(w_col);
  assign w_row_nd = f_ndig(w_row9);
  assign w_col_nd = f_ndig(w_col9);

  always_comb begin
    w_ld_last = 4'd3;
    case (w_ld_type)
      2'd0:    w_ld_last = 4'd3;
      2'd2:    w_ld_last = 4'd6;
      default: w_ld_last = 4'd3 + {2'b00, w_row_nd} + {2'b00, w_col_nd};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_type     <= 2'd0;
      r_row_bcd  <= 12'd0;
      r_row_nd   <= 2'd1;
      r_col_bcd  <= 12'd0;
      r_col_nd   <= 2'd1;
      r_last_idx <= 4'd0;
      r_idx      <= 4'd0;
    end else if (w_ld_vld) begin
      r_type     <= w_ld_type;
      r_row_bcd  <= f_bin2bcd(w_row9);
      r_row_nd   <= w_row_nd;
      r_col_bcd  <= f_bin2bcd(w_col9);
      r_col_nd   <= w_col_nd;
      r_last_idx <= w_ld_last;
      r_idx      <= 4'd0;
    end else if (w_xfer) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // CPR layout: 1B 5B <row digits> 3B <col digits> 52.
  logic [3:0] w_sep_idx;
  logic [3:0] w_col_end;
  logic [3:0] w_rel_row;
  logic [3:0] w_rel_col;

  assign w_sep_idx = 4'd2 + {2'b00, r_row_nd};
  assign w_col_end = w_sep_idx + 4'd1 + {2'b00, r_col_nd};
  assign w_rel_row = r_idx - 4'd2;
  assign w_rel_col = r_idx - w_sep_idx - 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_tx_vld    = 1'b0;
    w_tx_dat    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_ld_vld) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        w_tx_vld = 1'b1;
        if (w_xfer && w_last) w_state_nxt = w_ld_vld ? S_EMIT : S_IDLE;
        case (r_type)
          2'd0: begin
            case (r_idx)
              4'd0:    w_tx_dat = 8'h1B;
              4'd1:    w_tx_dat = 8'h5B;
              4'd2:    w_tx_dat = 8'h30;
              default: w_tx_dat = 8'h6E;
            endcase
          end
          2'd2: begin
            case (r_idx)
              4'd0:    w_tx_dat = 8'h1B;
              4'd1:    w_tx_dat = 8'h5B;
              4'd2:    w_tx_dat = 8'h3F;
              4'd3:    w_tx_dat = 8'h31;
              4'd4:    w_tx_dat = 8'h3B;
              4'd5:    w_tx_dat = 8'h32;
              default: w_tx_dat = 8'h63;
            endcase
          end
          default: begin
            if (r_idx == 4'd0)           w_tx_dat = 8'h1B;
            else if (r_idx == 4'd1)      w_tx_dat = 8'h5B;
            else if (r_idx < w_sep_idx)  w_tx_dat = f_digit(r_row_bcd, r_row_nd, w_rel_row[1:0]);
            else if (r_idx == w_sep_idx) w_tx_dat = 8'h3B;
            else if (r_idx < w_col_end)  w_tx_dat = f_digit(r_col_bcd, r_col_nd, w_rel_col[1:0]);
            else                         w_tx_dat = 8'h52;
          end
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign io_bus.txValid = w_tx_vld;
  assign io_bus.txData  = w_tx_dat;

endmodule
